// File: rtl/uart_cmd_ctrl_pkg.sv
// vga_cfg_pkg: shared definitions for the UART command sequencer that feeds
// the VGA configuration register file.
//   - state_t       : sequencer states (ACK is only reachable when the
//                     UART_CMD_ACK_EN build option is defined)
//   - SYNC_BYTE_DEF : default frame start marker
//   - ACK_BYTE/NAK_BYTE : reply bytes for accepted / rejected frames
//   - REG_IDX_W     : width of a configuration register index
//   - frame_chk()   : expected checksum of a SYNC/ADDR/DATA triple
package vga_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        ACK  = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] ACK_BYTE      = 8'h06;
    localparam logic [7:0] NAK_BYTE      = 8'h15;
    localparam int         REG_IDX_W     = 4;

    function automatic logic [7:0] frame_chk(input logic [7:0] sync_b,
                                             input logic [7:0] addr_b,
                                             input logic [7:0] data_b);
        return sync_b ^ addr_b ^ data_b;
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if: byte stream from the UART receiver, register write port
// towards the VGA config register file and, when UART_CMD_ACK_EN is defined,
// the reply byte stream towards the UART transmitter.
//   rx_data/rx_valid/rx_perr : received byte, strobe, parity error
//   wr_en/wr_addr/wr_data    : single-cycle register write
//   tx_data/tx_valid/tx_ready: reply byte handshake (UART_CMD_ACK_EN only)
// Modports: master = command sequencer, slave = surrounding system.
interface uart_cmd_ctrl_if;
    import vga_cfg_pkg::*;

    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_perr;
    logic                 wr_en;
    logic [REG_IDX_W-1:0] wr_addr;
    logic [7:0]           wr_data;
`ifdef UART_CMD_ACK_EN
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
`endif

    modport master (
        input  rx_data, rx_valid, rx_perr,
`ifdef UART_CMD_ACK_EN
        output tx_data, tx_valid,
        input  tx_ready,
`endif
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        output rx_data, rx_valid, rx_perr,
`ifdef UART_CMD_ACK_EN
        input  tx_data, tx_valid,
        output tx_ready,
`endif
        input  wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/uart_cmd_ctrl_timeout_cnt.sv
// cmd_timeout_cnt: inter-byte timeout counter. Clears while clr is high,
// otherwise counts up and parks at TIMEOUT-1, where expired is asserted.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear request (byte received or sequencer not in a frame)
//   expired  : counter has reached TIMEOUT-1
module cmd_timeout_cnt #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expired
);

    localparam int                CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses 4-byte frames SYNC, ADDR, DATA, CHK (CHK = SYNC^ADDR^
// DATA) from the UART receiver and issues one register write per accepted
// frame. Rejected frames (bad checksum, address out of range, parity error,
// inter-byte timeout) pulse frame_err and bump a saturating error counter.
// Build option: UART_CMD_ACK_EN adds an ACK state that sends 8'h06 / 8'h15
// over the tx handshake of the interface after every accepted / rejected frame.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : uart_cmd_ctrl_if.master (rx bytes in, register writes out)
//   frame_ok  : one-cycle pulse, frame accepted
//   frame_err : one-cycle pulse, frame rejected
//   err_count : saturating count of rejected frames
//   busy      : sequencer is not IDLE
//   last_byte : {rx_perr, rx_data} of the most recent received byte
module uart_cmd_ctrl import vga_cfg_pkg::*; #(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         NUM_REGS  = 16,
    parameter int         TIMEOUT   = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_cmd_ctrl_if.master        bus,
    output logic                   frame_ok,
    output logic                   frame_err,
    output logic [7:0]             err_count,
    output logic                   busy,
    output logic [8:0]             last_byte
);

    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

`ifdef UART_CMD_ACK_EN
    localparam state_t FRAME_END = ACK;
`else
    localparam state_t FRAME_END = IDLE;
`endif

    state_t     state_q, state_n;
    logic [7:0] addr_q, data_q;
    logic       accept_c, reject_c;
    logic       frame_good;
    logic       to_expired, to_clr;

    // The timeout only runs while a frame is being received.
    assign to_clr = bus.rx_valid || (state_q == IDLE) || (state_q == ACK);

    cmd_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (to_clr),
        .expired (to_expired)
    );

    assign frame_good = (frame_chk(SYNC_BYTE, addr_q, data_q) == bus.rx_data) &&
                        (addr_q[7:4] == 4'd0) && (addr_q < NUM_REGS_B);

    always_comb begin
        state_n  = state_q;
        accept_c = 1'b0;
        reject_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_valid && !bus.rx_perr && (bus.rx_data == SYNC_BYTE)) begin
                    state_n = ADDR;
                end
            end
            ADDR, DATA, CHK: begin
                // A byte arriving in the expiry cycle takes priority.
                if (bus.rx_valid) begin
                    if (bus.rx_perr) begin
                        reject_c = 1'b1;
                        state_n  = FRAME_END;
                    end else if (state_q == ADDR) begin
                        state_n = DATA;
                    end else if (state_q == DATA) begin
                        state_n = CHK;
                    end else begin
                        accept_c = frame_good;
                        reject_c = !frame_good;
                        state_n  = FRAME_END;
                    end
                end else if (to_expired) begin
                    reject_c = 1'b1;
                    state_n  = FRAME_END;
                end
            end
`ifdef UART_CMD_ACK_EN
            ACK: begin
                if (bus.tx_ready) begin
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= '0;
            last_byte   <= '0;
        end else begin
            state_q   <= state_n;
            bus.wr_en <= accept_c;
            frame_ok  <= accept_c;
            frame_err <= reject_c;
            if (accept_c) begin
                bus.wr_addr <= addr_q[REG_IDX_W-1:0];
                bus.wr_data <= data_q;
            end
            if (reject_c && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (bus.rx_valid) begin
                last_byte <= {bus.rx_perr, bus.rx_data};
                if (state_q == ADDR) addr_q <= bus.rx_data;
                if (state_q == DATA) data_q <= bus.rx_data;
            end
        end
    end

    assign busy = (state_q != IDLE);

`ifdef UART_CMD_ACK_EN
    logic ack_ok_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_ok_q <= 1'b0;
        end else if (accept_c || reject_c) begin
            ack_ok_q <= accept_c;
        end
    end

    assign bus.tx_valid = (state_q == ACK);
    assign bus.tx_data  = (state_q != ACK) ? 8'h00 : (ack_ok_q ? ACK_BYTE : NAK_BYTE);
`endif

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command sequencer between the UART receiver and the VGA configuration register file.
- Consumes received bytes, including the receiver's parity-error flag, and parses fixed 4-byte write frames.
- Checks sync, address range and checksum, then issues a single-cycle register write port transaction.
- Keeps error statistics for the debug 7-segment path and aborts stalled frames on an inter-byte timeout.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- NUM_REGS, 16, number of writable config registers; valid addresses are 0..NUM_REGS-1, NUM_REGS ≤ 16.
- TIMEOUT, 4096, max clk cycles allowed between bytes inside a frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data and rx_perr are valid while it is high.
- rx_perr  in  1  parity error on the current byte.
- wr_en  out  1  one-cycle register write strobe.
- wr_addr  out  4  register index.
- wr_data  out  8  register value.
- frame_ok  out  1  one-cycle pulse: frame accepted.
- frame_err  out  1  one-cycle pulse: frame rejected.
- err_count  out  8  saturating count of rejected frames.
- busy  out  1  high whenever state ≠ IDLE.
- last_byte  out  9  {rx_perr, rx_data} of the most recent rx_valid, for debug display.

Behaviour:
- Reset values: every output is 0, state = IDLE, timeout counter = 0. Reset mid-frame discards the partial frame with no error pulse.
- Frame format: SYNC, ADDR, DATA, CHK, where CHK = SYNC ^ ADDR ^ DATA.
- IDLE:
  - rx_valid with rx_data == SYNC_BYTE and !rx_perr -> ADDR.
  - Any other byte is ignored, with no error and no count.
- ADDR: on rx_valid, latch addr -> DATA.
- DATA: on rx_valid, latch data -> CHK.
- CHK: on rx_valid, evaluate the frame and go to IDLE (or to ACK when the optional feature is enabled).
  - Accept when the checksum matches and ADDR < NUM_REGS, which also requires ADDR[7:4] == 0.
  - Accept: in the next cycle, wr_en=1, wr_addr=ADDR[3:0], wr_data=DATA and frame_ok=1 (latency 1 clk after the CHK strobe).
  - Otherwise: frame_err=1 in the next cycle and no write.
- rx_perr on any byte in ADDR, DATA or CHK: abort to IDLE and pulse frame_err in the next cycle.
- Timeout:
  - The counter clears on every rx_valid and while in IDLE, and increments otherwise.
  - When it reaches TIMEOUT-1 in ADDR, DATA or CHK: go to IDLE, pulse frame_err.
  - If rx_valid arrives in the same cycle as expiry, the byte wins and the counter clears.
- err_count increments on every frame_err pulse and saturates at 8'hFF without wrapping.
- wr_addr and wr_data hold their last written values between writes. Only wr_en, frame_ok and frame_err are pulses.
- last_byte updates on every rx_valid in all states.
- A SYNC byte received mid-frame is treated as ordinary payload. There is no resynchronisation except via checksum failure or timeout.

Optional Feature:
- UART_CMD_ACK_EN defined:
  - Adds ports tx_data out 8, tx_valid out 1, tx_ready in 1, and an ACK state.
  - After each frame_ok or frame_err (not after bytes ignored in IDLE), enter ACK.
  - In ACK, hold tx_valid=1 with tx_data = 8'h06 (ok) or 8'h15 (err) until a cycle with tx_ready=1, then return to IDLE.
  - rx_valid bytes arriving in ACK are dropped silently. The timeout is inactive in ACK.
- UART_CMD_ACK_EN undefined: the tx ports and the ACK state are absent, and frame end returns directly to IDLE.

Decomposition:
- Shared package vga_cfg_pkg holds:
  - the state enum (IDLE, ADDR, DATA, CHK, ACK);
  - the SYNC_BYTE default;
  - the ACK_BYTE 8'h06 and NAK_BYTE 8'h15 constants;
  - the register index width constant 4.
- One natural sub-module, cmd_timeout_cnt: a clearable counter with an expiry flag, parameterised by TIMEOUT.

Test Plan:
- Bytes A5 03 7F D9 -> wr_en for 1 clk with wr_addr=3, wr_data=8'h7F one clk after the D9 strobe; frame_ok=1; err_count=0.
- Bytes A5 03 7F D8 -> frame_err pulse, no wr_en, err_count=1.
- Bytes A5 13 7F C9 (checksum correct, address out of range) -> frame_err, no write.
- Bytes A5 03, then stall 4096 clks -> frame_err at expiry, busy=0. A following valid frame A5 05 10 B0 writes reg 5 = 8'h10.
- A5 03, then 7F with rx_perr=1 -> abort, frame_err, err_count increments. Drive 300 bad frames -> err_count saturates at 8'hFF.
- With UART_CMD_ACK_EN defined: hold tx_ready=0 for 10 clks after A5 03 7F D9 -> tx_valid held with tx_data=8'h06. Bytes sent during ACK are ignored. Raise tx_ready -> return to IDLE next clk.
